cpu_int_seq: RTL
================

# cpu_int_seq

Parametrised interrupt/reset sequencer for the 6502-style CPU. At an instruction boundary it arbitrates among reset, NMI, BRK and NUM_IRQ maskable interrupt lines, pushes PCH/PCL/P onto the stack, fetches the 16-bit vector and hands the new PC, S and I-flag back to the CPU core. It owns the memory bus only while `busy` is high; the core muxes `adr_bus`/`data_bus_out`/`RW` from this block at those times.

## Interface
- NUM_IRQ, 4: number of maskable IRQ lines (1..8)
- VECTORED, 0: 0 = all IRQs share IRQ_VEC; 1 = channel k uses IRQ_TBL + 2k
- STACK_PAGE, 8'h01: stack high byte
- NMI_VEC, 16'hFFFA / RST_VEC, 16'hFFFC / IRQ_VEC, 16'hFFFE: vector addresses
- IRQ_TBL, 16'hFFE0: vectored table base
- clk  in  1  clock; all state changes on falling edge, same as CPU core
- n_reset  in  1  asynchronous, active-low reset
- irq_n  in  NUM_IRQ  level-sensitive, active-low IRQ lines
- irq_mask  in  NUM_IRQ  1 = channel disabled
- nmi_n  in  1  active-low NMI, falling-edge triggered
- flag_i  in  1  CPU interrupt-disable flag
- brk_req  in  1  CPU decoded BRK, valid with boundary
- boundary  in  1  CPU in state 0 (opcode fetch edge)
- pc_in  in  16  PC to push (BRK: already PC+2)
- p_in  in  8  processor status to push
- s_in  in  8  current stack pointer
- data_bus_in  in  8  memory read data
- busy  out  1  sequencer owns bus; CPU stalls
- adr_bus  out  16  address while busy
- data_bus_out  out  8  write data
- RW  out  1  1 = read, 0 = write
- pc_out  out  16  new PC; s_out  out  8  new S
- pc_load  out  1  one-cycle strobe: load pc_out, s_out, set I flag
- irq_cause  out  3  0 reset, 1 NMI, 2 BRK, 3 IRQ; irq_chan  out  3  serviced IRQ channel

## Operation
- States: IDLE, PUSH_H, PUSH_L, PUSH_P, VEC_LO, VEC_HI, DONE.
- Reset: async assert -> state IDLE, rst_pending=1, nmi_pending=0, all outputs 0 except RW=1. First falling edge after release: rst_pending cleared, enter VEC_LO with vector RST_VEC, s_out=8'hFD, no pushes, `boundary` not required.
- NMI detect: nmi_n sampled each edge; 1->0 sets nmi_pending. Cleared only on accept of an NMI sequence. A new edge during a sequence stays pending.
- Accept in IDLE when boundary=1, priority NMI > BRK > IRQ. IRQ eligible iff flag_i=0 and any (~irq_n & ~irq_mask); channel = lowest such index. None eligible -> stay IDLE, busy=0.
- PUSH_H/L/P: adr_bus={STACK_PAGE,S}, RW=0, data = pc_in[15:8], pc_in[7:0], then p_in with bit5=1 and bit4 = (cause==BRK); S decremented after each push (8-bit wrap, 00->FF).
- VEC_LO: adr_bus=vector, RW=1. VEC_HI: capture data_bus_in as low byte, adr_bus=vector+1. DONE: capture high byte, pc_load=1, pc_out={hi,lo}, s_out=S; next edge -> IDLE.
- Vector select: NMI NMI_VEC; BRK IRQ_VEC; IRQ IRQ_VEC, or IRQ_TBL+2*chan when VECTORED=1.
- pc_in, p_in, s_in latched at accept; later changes ignored.
- IRQ line released mid-sequence: sequence completes with latched channel.

## Timing
- Accept edge -> busy=1 and PUSH_H outputs same edge.
- Interrupt: 6 cycles busy (3 push, VEC_LO, VEC_HI, DONE); pc_load high in 6th cycle.
- Reset: 3 cycles busy (VEC_LO, VEC_HI, DONE).
- Memory latency 1 cycle: address driven at edge n, data captured at edge n+1.
- pc_load exactly one cycle wide; busy drops on the edge after DONE.
- Reset mid-sequence: immediate abort to reset values, reset sequence restarts on release.

## Test plan
- Reset release, mem[FFFC]=00, mem[FFFD]=80 -> pc_load after 3 cycles, pc_out=8000, s_out=FD, cause 0, no writes.
- IRQ ch2 low, flag_i=0, pc_in=1234, p_in=C3, s_in=FF -> writes 01FF=12, 01FE=34, 01FD=E3; reads FFFE/FFFF; s_out=FC; irq_chan=2.
- VECTORED=1, ch1 and ch3 low -> ch1 serviced, vector read from FFE2/FFE3.
- NMI falling edge and IRQ at same boundary -> NMI via FFFA; IRQ serviced at next boundary; flag_i=1 or mask -> IRQ ignored.
- BRK with p_in=C3 -> pushed P=F3; second NMI edge during sequence -> serviced next boundary.
- n_reset low in VEC_HI -> outputs to reset values, busy=0; release -> reset sequence.

Source files
------------

// File: rtl/cpu_int_seq_if.sv
// ---------------------------------------------------------------------------
// cpu_int_seq_if
// Bundle of all non-clock/non-reset signals between the CPU core and the
// interrupt/reset sequencer.
//   slave  modport : sequencer side (inputs: IRQ/NMI/BRK request, CPU state,
//                    read data; outputs: bus drive, new PC/S, cause info)
//   master modport : CPU core side (mirror image of slave)
// ---------------------------------------------------------------------------
interface cpu_int_seq_if #(
  parameter int NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq_n;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               nmi_n;
  logic               flag_i;
  logic               brk_req;
  logic               boundary;
  logic [15:0]        pc_in;
  logic [7:0]         p_in;
  logic [7:0]         s_in;
  logic [7:0]         data_bus_in;
  logic               busy;
  logic [15:0]        adr_bus;
  logic [7:0]         data_bus_out;
  logic               RW;
  logic [15:0]        pc_out;
  logic [7:0]         s_out;
  logic               pc_load;
  logic [2:0]         irq_cause;
  logic [2:0]         irq_chan;

  modport slave (
    input  irq_n, irq_mask, nmi_n, flag_i, brk_req, boundary,
    input  pc_in, p_in, s_in, data_bus_in,
    output busy, adr_bus, data_bus_out, RW,
    output pc_out, s_out, pc_load, irq_cause, irq_chan
  );

  modport master (
    output irq_n, irq_mask, nmi_n, flag_i, brk_req, boundary,
    output pc_in, p_in, s_in, data_bus_in,
    input  busy, adr_bus, data_bus_out, RW,
    input  pc_out, s_out, pc_load, irq_cause, irq_chan
  );
endinterface

// File: rtl/cpu_int_seq.sv
// ---------------------------------------------------------------------------
// cpu_int_seq
// Interrupt/reset sequencer for a 6502-style core. At an instruction boundary
// it arbitrates reset > NMI > BRK > IRQ, pushes PCH/PCL/P to the stack, reads
// the 16-bit vector and strobes the new PC/S back to the core.
// All state changes happen on the falling clock edge, like the core.
// Ports:
//   clk      : clock (falling-edge active)
//   n_reset  : asynchronous active-low reset
//   bus      : cpu_int_seq_if.slave (requests, CPU state, memory bus,
//              pc_out/s_out/pc_load strobe, irq_cause/irq_chan)
// All bus outputs are registered; they are computed from the next state so
// that the first push is already on the bus in the cycle after the accept
// edge.
// ---------------------------------------------------------------------------
module cpu_int_seq #(
  parameter int          NUM_IRQ    = 4,
  parameter bit          VECTORED   = 1'b0,
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] NMI_VEC    = 16'hFFFA,
  parameter logic [15:0] RST_VEC    = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC    = 16'hFFFE,
  parameter logic [15:0] IRQ_TBL    = 16'hFFE0
) (
  input  logic        clk,
  input  logic        n_reset,
  cpu_int_seq_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PUSH_H = 3'd1,
    ST_PUSH_L = 3'd2,
    ST_PUSH_P = 3'd3,
    ST_VEC_LO = 3'd4,
    ST_VEC_HI = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  localparam logic [2:0] CAUSE_RST = 3'd0;
  localparam logic [2:0] CAUSE_NMI = 3'd1;
  localparam logic [2:0] CAUSE_BRK = 3'd2;
  localparam logic [2:0] CAUSE_IRQ = 3'd3;

  // Status byte as pushed: bit5 always set, bit4 (B) set only for BRK.
  function automatic logic [7:0] push_status(input logic [7:0] p, input logic is_brk);
    push_status = {p[7:6], 1'b1, is_brk, p[3:0]};
  endfunction

  // Internal state
  state_t      r_state;
  logic [7:0]  r_s;
  logic [15:0] r_vec;
  logic [15:0] r_pc;
  logic [7:0]  r_p;
  logic [2:0]  r_cause;
  logic [2:0]  r_chan;
  logic [7:0]  r_lo;
  logic        r_nmi_prev;
  logic        r_nmi_pending;
  logic        r_rst_pending;
  // Registered outputs
  logic [15:0] r_pc_out;
  logic [7:0]  r_s_out;
  logic        r_busy;
  logic [15:0] r_adr;
  logic [7:0]  r_dout;
  logic        r_rw;
  logic        r_pc_load;

  // Next-state wires
  state_t      w_state_nxt;
  logic [7:0]  w_s_nxt;
  logic [15:0] w_vec_nxt;
  logic [15:0] w_pc_nxt;
  logic [7:0]  w_p_nxt;
  logic [2:0]  w_cause_nxt;
  logic [2:0]  w_chan_nxt;
  logic [7:0]  w_lo_nxt;
  logic        w_nmi_pending_nxt;
  logic        w_rst_pending_nxt;
  logic [15:0] w_pc_out_nxt;
  logic [7:0]  w_s_out_nxt;
  logic        w_busy_nxt;
  logic [15:0] w_adr_nxt;
  logic [7:0]  w_dout_nxt;
  logic        w_rw_nxt;
  logic        w_pc_load_nxt;

  logic        w_nmi_fall;
  logic        w_nmi_pend;
  logic        w_irq_any;
  logic [2:0]  w_irq_chan;
  logic [15:0] w_irq_vec;

  // An edge seen on the accept cycle itself is honoured immediately.
  assign w_nmi_fall = r_nmi_prev & ~bus.nmi_n;
  assign w_nmi_pend = r_nmi_pending | w_nmi_fall;

  // IRQ eligibility and lowest-index channel select (descending scan so the
  // lowest active channel is the last one written).
  always_comb begin
    w_irq_any  = 1'b0;
    w_irq_chan = 3'd0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      w_irq_chan = (~bus.irq_n[k] & ~bus.irq_mask[k]) ? 3'(k) : w_irq_chan;
      w_irq_any  = w_irq_any | (~bus.irq_n[k] & ~bus.irq_mask[k]);
    end
    w_irq_any = w_irq_any & ~bus.flag_i;
  end

  assign w_irq_vec = VECTORED ? (IRQ_TBL + {12'h000, w_irq_chan, 1'b0}) : IRQ_VEC;

  // Next-state and datapath-update logic of the sequencer FSM.
  always_comb begin
    w_state_nxt       = r_state;
    w_s_nxt           = r_s;
    w_vec_nxt         = r_vec;
    w_pc_nxt          = r_pc;
    w_p_nxt           = r_p;
    w_cause_nxt       = r_cause;
    w_chan_nxt        = r_chan;
    w_lo_nxt          = r_lo;
    w_nmi_pending_nxt = w_nmi_pend;
    w_rst_pending_nxt = r_rst_pending;
    w_pc_out_nxt      = r_pc_out;
    w_s_out_nxt       = r_s_out;
    case (r_state)
      ST_IDLE: begin
        // CPU context is sampled every idle cycle; only the accept cycle's
        // copy survives into the push states.
        w_pc_nxt = bus.pc_in;
        w_p_nxt  = bus.p_in;
        w_s_nxt  = bus.s_in;
        if (r_rst_pending) begin
          // Reset sequence: no pushes, no boundary needed, S forced to FD.
          w_rst_pending_nxt = 1'b0;
          w_state_nxt       = ST_VEC_LO;
          w_vec_nxt         = RST_VEC;
          w_s_nxt           = 8'hFD;
          w_cause_nxt       = CAUSE_RST;
          w_chan_nxt        = 3'd0;
        end else if (bus.boundary && w_nmi_pend) begin
          w_state_nxt       = ST_PUSH_H;
          w_vec_nxt         = NMI_VEC;
          w_cause_nxt       = CAUSE_NMI;
          w_chan_nxt        = 3'd0;
          w_nmi_pending_nxt = 1'b0;
        end else if (bus.boundary && bus.brk_req) begin
          w_state_nxt = ST_PUSH_H;
          w_vec_nxt   = IRQ_VEC;
          w_cause_nxt = CAUSE_BRK;
          w_chan_nxt  = 3'd0;
        end else if (bus.boundary && w_irq_any) begin
          w_state_nxt = ST_PUSH_H;
          w_vec_nxt   = w_irq_vec;
          w_cause_nxt = CAUSE_IRQ;
          w_chan_nxt  = w_irq_chan;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PUSH_H: begin
        w_state_nxt = ST_PUSH_L;
        w_s_nxt     = r_s - 8'd1;
      end
      ST_PUSH_L: begin
        w_state_nxt = ST_PUSH_P;
        w_s_nxt     = r_s - 8'd1;
      end
      ST_PUSH_P: begin
        w_state_nxt = ST_VEC_LO;
        w_s_nxt     = r_s - 8'd1;
      end
      ST_VEC_LO: begin
        // Read data for the low vector address is valid this edge.
        w_state_nxt = ST_VEC_HI;
        w_lo_nxt    = bus.data_bus_in;
      end
      ST_VEC_HI: begin
        w_state_nxt  = ST_DONE;
        w_pc_out_nxt = {bus.data_bus_in, r_lo};
        w_s_out_nxt  = r_s;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bus output values for the state being entered at this edge.
  always_comb begin
    w_busy_nxt    = 1'b0;
    w_adr_nxt     = 16'h0000;
    w_dout_nxt    = 8'h00;
    w_rw_nxt      = 1'b1;
    w_pc_load_nxt = 1'b0;
    case (w_state_nxt)
      ST_PUSH_H: begin
        w_busy_nxt = 1'b1;
        w_adr_nxt  = {STACK_PAGE, w_s_nxt};
        w_rw_nxt   = 1'b0;
        w_dout_nxt = w_pc_nxt[15:8];
      end
      ST_PUSH_L: begin
        w_busy_nxt = 1'b1;
        w_adr_nxt  = {STACK_PAGE, w_s_nxt};
        w_rw_nxt   = 1'b0;
        w_dout_nxt = w_pc_nxt[7:0];
      end
      ST_PUSH_P: begin
        w_busy_nxt = 1'b1;
        w_adr_nxt  = {STACK_PAGE, w_s_nxt};
        w_rw_nxt   = 1'b0;
        w_dout_nxt = push_status(w_p_nxt, w_cause_nxt == CAUSE_BRK);
      end
      ST_VEC_LO: begin
        w_busy_nxt = 1'b1;
        w_adr_nxt  = w_vec_nxt;
      end
      ST_VEC_HI: begin
        w_busy_nxt = 1'b1;
        w_adr_nxt  = w_vec_nxt + 16'd1;
      end
      ST_DONE: begin
        w_busy_nxt    = 1'b1;
        w_pc_load_nxt = 1'b1;
      end
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs, falling-edge clocked with async reset.
  always_ff @(negedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state       <= ST_IDLE;
      r_s           <= 8'h00;
      r_vec         <= 16'h0000;
      r_pc          <= 16'h0000;
      r_p           <= 8'h00;
      r_cause       <= 3'd0;
      r_chan        <= 3'd0;
      r_lo          <= 8'h00;
      r_nmi_prev    <= 1'b1;
      r_nmi_pending <= 1'b0;
      r_rst_pending <= 1'b1;
      r_pc_out      <= 16'h0000;
      r_s_out       <= 8'h00;
      r_busy        <= 1'b0;
      r_adr         <= 16'h0000;
      r_dout        <= 8'h00;
      r_rw          <= 1'b1;
      r_pc_load     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_s           <= w_s_nxt;
      r_vec         <= w_vec_nxt;
      r_pc          <= w_pc_nxt;
      r_p           <= w_p_nxt;
      r_cause       <= w_cause_nxt;
      r_chan        <= w_chan_nxt;
      r_lo          <= w_lo_nxt;
      r_nmi_prev    <= bus.nmi_n;
      r_nmi_pending <= w_nmi_pending_nxt;
      r_rst_pending <= w_rst_pending_nxt;
      r_pc_out      <= w_pc_out_nxt;
      r_s_out       <= w_s_out_nxt;
      r_busy        <= w_busy_nxt;
      r_adr         <= w_adr_nxt;
      r_dout        <= w_dout_nxt;
      r_rw          <= w_rw_nxt;
      r_pc_load     <= w_pc_load_nxt;
    end
  end

  assign bus.busy         = r_busy;
  assign bus.adr_bus      = r_adr;
  assign bus.data_bus_out = r_dout;
  assign bus.RW           = r_rw;
  assign bus.pc_out       = r_pc_out;
  assign bus.s_out        = r_s_out;
  assign bus.pc_load      = r_pc_load;
  assign bus.irq_cause    = r_cause;
  assign bus.irq_chan     = r_chan;

endmodule
